sort_nxw_oddeven_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's fixed 4x8b bubble sorter.
- Sorts N unsigned W-bit keys with an odd-even transposition network, one register stage per network stage.
- Adds a valid/ready handshake with backpressure, a per-transaction ascending/descending mode, and a permutation output giving each result's source lane.
- Sits between a packed-vector producer and consumer in the datapath; accepts and delivers one vector per cycle.

---
 rtl/sort_pkg.sv | 28 ++
 rtl/sort_oe_stage.sv | 55 +++++
 rtl/sort_nxw_oddeven_pipe.sv | 69 ++++++
 tb/tb_sort_nxw_oddeven_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared helpers for the odd-even transposition sorter: index width,
// compare-exchange decision and per-stage pairing parity.
package sort_pkg;

    localparam int KEY_MAX_W = 32;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...
    function automatic parity_e stage_parity(input int s);
        return (s % 2 == 0) ? PAR_EVEN : PAR_ODD;
    endfunction

    // Strict comparison: equal keys never swap, which keeps the sort stable.
    function automatic logic cmp_swap(input logic [KEY_MAX_W-1:0] a,
                                      input logic [KEY_MAX_W-1:0] b,
                                      input logic                 desc);
        return desc ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/sort_oe_stage.sv
// One registered compare-exchange layer of the odd-even network; indices
// travel with their keys so the final layer yields the source permutation.
module sort_oe_stage
    import sort_pkg::*;
#(
    parameter int      N      = 4,
    parameter int      W      = 8,
    parameter parity_e PARITY = PAR_EVEN,
    localparam int     IW     = idx_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            prev_valid,
    input  logic            prev_desc,
    input  logic [N*W-1:0]  prev_keys,
    input  logic [N*IW-1:0] prev_idx,
    output logic            valid,
    output logic            desc,
    output logic [N*W-1:0]  keys,
    output logic [N*IW-1:0] idx
);

    logic [N*W-1:0]  nxt_keys;
    logic [N*IW-1:0] nxt_idx;

    always_comb begin
        nxt_keys = prev_keys;
        nxt_idx  = prev_idx;
        for (int i = int'(PARITY); i + 1 < N; i += 2) begin
            if (cmp_swap(KEY_MAX_W'(prev_keys[i*W +: W]),
                         KEY_MAX_W'(prev_keys[(i+1)*W +: W]), prev_desc)) begin
                nxt_keys[i*W +: W]      = prev_keys[(i+1)*W +: W];
                nxt_keys[(i+1)*W +: W]  = prev_keys[i*W +: W];
                nxt_idx[i*IW +: IW]     = prev_idx[(i+1)*IW +: IW];
                nxt_idx[(i+1)*IW +: IW] = prev_idx[i*IW +: IW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            desc  <= 1'b0;
            keys  <= '0;
            idx   <= '0;
        end else if (en) begin
            valid <= prev_valid;
            desc  <= prev_desc;
            keys  <= nxt_keys;
            idx   <= nxt_idx;
        end
    end

endmodule

// File: rtl/sort_nxw_oddeven_pipe.sv
// Pipelined N-lane odd-even transposition sorter with valid/ready flow control,
// per-vector sort direction and source-lane permutation output.
module sort_nxw_oddeven_pipe
    import sort_pkg::*;
#(
    parameter int  N  = 4,
    parameter int  W  = 8,
    localparam int IW = idx_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_desc,
    input  logic [N*W-1:0]  data_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  data_out,
    output logic [N*IW-1:0] perm_out
);

    logic            en;
    logic            valid_c [N+1];
    logic            desc_c  [N+1];
    logic [N*W-1:0]  keys_c  [N+1];
    logic [N*IW-1:0] idx_c   [N+1];
    logic [N*IW-1:0] ident;

    // Single global advance: a stalled output freezes the whole pipe, bubbles included.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        ident = '0;
        for (int i = 0; i < N; i++) begin
            ident[i*IW +: IW] = IW'(i);
        end
    end

    assign valid_c[0] = in_valid;
    assign desc_c[0]  = in_desc;
    assign keys_c[0]  = data_in;
    assign idx_c[0]   = ident;

    for (genvar s = 0; s < N; s++) begin : g_stage
        sort_oe_stage #(
            .N      (N),
            .W      (W),
            .PARITY (stage_parity(s))
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .prev_valid (valid_c[s]),
            .prev_desc  (desc_c[s]),
            .prev_keys  (keys_c[s]),
            .prev_idx   (idx_c[s]),
            .valid      (valid_c[s+1]),
            .desc       (desc_c[s+1]),
            .keys       (keys_c[s+1]),
            .idx        (idx_c[s+1])
        );
    end

    assign out_valid = valid_c[N];
    assign data_out  = keys_c[N];
    assign perm_out  = idx_c[N];

endmodule

// File: tb/tb_sort_nxw_oddeven_pipe.sv
// Self-checking bench for sort_nxw_oddeven_pipe: directed vectors, random
// streams, backpressure and mid-flight reset against a stable-sort model.
module tb_sort_nxw_oddeven_pipe;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            in_desc;
    logic [N*W-1:0]  data_in;
    logic            out_valid;
    logic            out_ready;
    logic [N*W-1:0]  data_out;
    logic [N*IW-1:0] perm_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sort_nxw_oddeven_pipe #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_desc   (in_desc),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .perm_out  (perm_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stable insertion sort: keys move only past strictly out-of-order neighbours.
    function automatic void ref_sort(input  logic [N*W-1:0]  din,
                                     input  logic            desc,
                                     output logic [N*W-1:0]  dout,
                                     output logic [N*IW-1:0] pout);
        logic [W-1:0]  k [N];
        logic [IW-1:0] ix [N];
        logic [W-1:0]  tk;
        logic [IW-1:0] ti;
        for (int i = 0; i < N; i++) begin
            k[i]  = din[i*W +: W];
            ix[i] = IW'(i);
        end
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? (k[j-1] < k[j]) : (k[j-1] > k[j])) begin
                    tk = k[j-1]; k[j-1] = k[j]; k[j] = tk;
                    ti = ix[j-1]; ix[j-1] = ix[j]; ix[j] = ti;
                end else begin
                    break;
                end
            end
        end
        dout = '0;
        pout = '0;
        for (int i = 0; i < N; i++) begin
            dout[i*W +: W]   = k[i];
            pout[i*IW +: IW] = ix[i];
        end
    endfunction

    // Half the lanes draw from a tiny range so ties are common.
    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) v[i*W +: W] = W'($urandom_range(0, 3));
            else                           v[i*W +: W] = W'($urandom);
        end
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_desc = 1'b0; data_in = '0; out_ready = 1'b1;
        #3;
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (data_out !== '0)     begin errors++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        checks++; if (perm_out !== '0)     begin errors++; $display("FAIL reset_perm_out: got %h expected 0", perm_out); end
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_single(input string name, input logic [N*W-1:0] din, input logic desc,
                               input logic [N*W-1:0] exp_d, input logic [N*IW-1:0] exp_p);
        logic [N*W-1:0]  md;
        logic [N*IW-1:0] mp;
        ref_sort(din, desc, md, mp);
        out_ready = 1'b1;
        in_valid = 1'b1; data_in = din; in_desc = desc;
        step();
        in_valid = 1'b0;
        for (int c = 1; c < N; c++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early: out_valid %b expected 0 at cycle %0d", name, out_valid, c); end
            step();
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b expected 1", name, out_valid); end
        checks++; if (data_out !== exp_d) begin errors++; $display("FAIL %s_data: got %h expected %h", name, data_out, exp_d); end
        checks++; if (perm_out !== exp_p) begin errors++; $display("FAIL %s_perm: got %h expected %h", name, perm_out, exp_p); end
        checks++; if (data_out !== md || perm_out !== mp) begin errors++; $display("FAIL %s_model: got %h/%h expected %h/%h", name, data_out, perm_out, md, mp); end
        step();
    endtask

    task automatic test_directed();
        test_single("asc",      32'h20301040, 1'b0, 32'h40302010, 8'h2D);
        test_single("desc",     32'h20301040, 1'b1, 32'h10203040, 8'h78);
        test_single("tie_asc",  32'h05050505, 1'b0, 32'h05050505, 8'hE4);
        test_single("tie_desc", 32'h05050505, 1'b1, 32'h05050505, 8'hE4);
        // sources per output lane 0..3 = 1,3,0,2
        test_single("edge_asc", 32'h00FF00FF, 1'b0, 32'hFFFF0000, 8'h8D);
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0]  qd[$];
        logic [N*IW-1:0] qp[$];
        logic [N*W-1:0]  v, md;
        logic [N*IW-1:0] mp;
        logic            exp_v;
        int              got = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 8 + N + 2; t++) begin
            if (t < 8) begin
                v = rand_vec();
                in_valid = 1'b1; data_in = v; in_desc = t[0];
                ref_sort(v, t[0], md, mp);
                qd.push_back(md); qp.push_back(mp);
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1 at t=%0d", in_ready, t); end
            end else begin
                in_valid = 1'b0;
            end
            step();
            exp_v = (t >= N - 1) && (t < N - 1 + 8);
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL b2b_valid: got %b expected %b at t=%0d", out_valid, exp_v, t); end
            if (out_valid === 1'b1) begin
                if (qd.size() == 0) begin
                    checks++; errors++; $display("FAIL b2b_extra: unexpected result %h", data_out);
                end else begin
                    md = qd.pop_front(); mp = qp.pop_front(); got++;
                    checks++; if (data_out !== md || perm_out !== mp) begin errors++; $display("FAIL b2b_result: got %h/%h expected %h/%h", data_out, perm_out, md, mp); end
                end
            end
        end
        checks++; if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", got); end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0]  qd[$];
        logic [N*IW-1:0] qp[$];
        logic [N*W-1:0]  v, md, snap_d;
        logic [N*IW-1:0] mp, snap_p;
        logic            d;
        int              got = 0;
        out_ready = 1'b0;
        for (int t = 0; t < N; t++) begin
            v = rand_vec(); d = 1'($urandom_range(0, 1));
            in_valid = 1'b1; data_in = v; in_desc = d;
            ref_sort(v, d, md, mp);
            qd.push_back(md); qp.push_back(mp);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready: got %b expected 1 at t=%0d", in_ready, t); end
            step();
        end
        data_in = rand_vec();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid: got %b expected 1", out_valid); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
        snap_d = data_out; snap_p = perm_out;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_hs: ready %b valid %b expected 0/1", in_ready, out_valid); end
            checks++; if (data_out !== snap_d || perm_out !== snap_p) begin errors++; $display("FAIL bp_hold_stable: got %h/%h expected %h/%h", data_out, perm_out, snap_d, snap_p); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 3 * N; t++) begin
            if (out_valid === 1'b1) begin
                if (qd.size() == 0) begin
                    checks++; errors++; $display("FAIL bp_extra: unexpected result %h", data_out);
                end else begin
                    md = qd.pop_front(); mp = qp.pop_front(); got++;
                    checks++; if (data_out !== md || perm_out !== mp) begin errors++; $display("FAIL bp_result: got %h/%h expected %h/%h", data_out, perm_out, md, mp); end
                end
            end
            step();
        end
        checks++; if (got != N) begin errors++; $display("FAIL bp_count: got %0d expected %0d", got, N); end
    endtask

    task automatic test_reset_flight();
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1; data_in = rand_vec(); in_desc = t[0];
            step();
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rf_pre_valid: got %b expected 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_async_valid: got %b expected 0", out_valid); end
        checks++; if (data_out !== '0 || perm_out !== '0) begin errors++; $display("FAIL rf_async_clear: got %h/%h expected 0/0", data_out, perm_out); end
        step();
        #2 rst = 1'b0;
        for (int c = 0; c < 2 * N; c++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_flushed: got %b expected 0 at cycle %0d", out_valid, c); end
        end
        test_single("rf_after", 32'h20301040, 1'b0, 32'h40302010, 8'h2D);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
